// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with operand forwarding.
//   clk, rst_n              : clock, async active-low reset
//   idValid / idReady       : handshake from decode (idReady = ~stall)
//   id*                     : decoded operands, indices, immediate, opcode
//   exMem* / memWb*         : forwarding sources from later stages
//   stall / flush           : hazard hold / squash (flush has priority)
//   aluInput1/2, aluControl : forwarded operands and registered opcode
//   exValid, exRd, exRegWrite : EX-stage status
//   fwdSel1/2               : forwarding selection (0 reg, 1 EX/MEM, 2 MEM/WB, 3 imm)
module id_ex_stage #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned REG_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                idValid,
  output logic                idReady,
  input  logic [WIDTH-1:0]    idOp1Data,
  input  logic [WIDTH-1:0]    idOp2Data,
  input  logic [REG_BITS-1:0] idRs1,
  input  logic [REG_BITS-1:0] idRs2,
  input  logic [REG_BITS-1:0] idRd,
  input  logic                idRegWrite,
  input  logic                idUseImm,
  input  logic [WIDTH-1:0]    idImm,
  input  logic [3:0]          idAluControl,
  input  logic                exMemRegWrite,
  input  logic [REG_BITS-1:0] exMemRd,
  input  logic [WIDTH-1:0]    exMemResult,
  input  logic                memWbRegWrite,
  input  logic [REG_BITS-1:0] memWbRd,
  input  logic [WIDTH-1:0]    memWbResult,
  input  logic                stall,
  input  logic                flush,
  output logic [WIDTH-1:0]    aluInput1,
  output logic [WIDTH-1:0]    aluInput2,
  output logic [3:0]          aluControl,
  output logic                exValid,
  output logic [REG_BITS-1:0] exRd,
  output logic                exRegWrite,
  output logic [1:0]          fwdSel1,
  output logic [1:0]          fwdSel2
);

  logic [WIDTH-1:0]    op1_q, op1_d, op2_q, op2_d;
  logic [REG_BITS-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                use_imm_q, use_imm_d;
  logic                reg_write_q, reg_write_d;
  logic [3:0]          alu_ctl_q, alu_ctl_d;
  logic                valid_q, valid_d;

  assign idReady    = ~stall;
  assign aluControl = alu_ctl_q;
  assign exRd       = rd_q;
  assign exValid    = valid_q;
  assign exRegWrite = reg_write_q & valid_q;

  // Forwarding mux; EX/MEM is the younger result so it is checked first.
  always_comb begin
    aluInput1 = op1_q;
    fwdSel1   = 2'd0;
    if (exMemRegWrite && exMemRd == rs1_q && rs1_q != '0) begin
      aluInput1 = exMemResult;
      fwdSel1   = 2'd1;
    end else if (memWbRegWrite && memWbRd == rs1_q && rs1_q != '0) begin
      aluInput1 = memWbResult;
      fwdSel1   = 2'd2;
    end

    aluInput2 = op2_q;
    fwdSel2   = 2'd0;
    if (use_imm_q) begin
      fwdSel2 = 2'd3;
    end else if (exMemRegWrite && exMemRd == rs2_q && rs2_q != '0) begin
      aluInput2 = exMemResult;
      fwdSel2   = 2'd1;
    end else if (memWbRegWrite && memWbRd == rs2_q && rs2_q != '0) begin
      aluInput2 = memWbResult;
      fwdSel2   = 2'd2;
    end
  end

  always_comb begin
    op1_d       = op1_q;
    op2_d       = op2_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    use_imm_d   = use_imm_q;
    reg_write_d = reg_write_q;
    alu_ctl_d   = alu_ctl_q;
    valid_d     = valid_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (stall) begin
      // Capture forwarded values so they survive once the producer retires.
      op1_d = aluInput1;
      if (!use_imm_q) op2_d = aluInput2;
    end else if (idValid) begin
      op1_d       = idOp1Data;
      op2_d       = idUseImm ? idImm : idOp2Data;
      rs1_d       = idRs1;
      rs2_d       = idRs2;
      rd_d        = idRd;
      use_imm_d   = idUseImm;
      reg_write_d = idRegWrite;
      alu_ctl_d   = idAluControl;
      valid_d     = 1'b1;
    end else begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q       <= '0;
      op2_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
      alu_ctl_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      use_imm_q   <= use_imm_d;
      reg_write_q <= reg_write_d;
      alu_ctl_q   <= alu_ctl_d;
      valid_q     <= valid_d;
    end
  end

endmodule
